// File: rtl/interval_timer_pkg.sv
// Shared types for the interval timer controller and its counter datapath.
package interval_timer_pkg;
    typedef enum logic {IDLE, RUN} state_e;
    typedef enum logic {ONE_SHOT, PERIODIC} mode_e;
endpackage

// File: rtl/timer_counter.sv
// Free-running up-counter resource; clear wins over enable.
module timer_counter #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [Width-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (enable)    count <= count + Width'(1);
    end
endmodule

// File: rtl/interval_timer.sv
// Interval timer controller: config latch, IDLE/RUN FSM driving the counter,
// registered expiry pulse and sticky pending/overrun flags.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [Width-1:0] cfg_period,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
    output logic             busy,
    output logic [Width-1:0] count,
    output logic             expired,
    output logic             pending,
    output logic             overrun
);
    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [Width-1:0] period_q;
    logic [Width-1:0] eff_period;
    logic [Width-1:0] last;
    logic             cfg_fire;
    logic             terminal;
    logic             clear, enable, expire;
    logic             expired_q, pending_q, overrun_q;

    assign cfg_ready  = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign cfg_fire   = cfg_valid && cfg_ready;
    // A start coinciding with a config handshake uses the incoming period.
    assign eff_period = cfg_fire ? cfg_period : period_q;
    assign last       = period_q - Width'(1);
    assign terminal   = (count == last);

    always_comb begin
        state_d = state_q;
        clear   = 1'b1;
        enable  = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop && eff_period != '0) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end else if (terminal) begin
                    expire = 1'b1;
                    if (mode_q == ONE_SHOT) state_d = IDLE;
                end else begin
                    clear  = 1'b0;
                    enable = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            period_q  <= '0;
            mode_q    <= ONE_SHOT;
            expired_q <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            expired_q <= expire;
            if (cfg_fire) begin
                period_q <= cfg_period;
                mode_q   <= cfg_periodic ? PERIODIC : ONE_SHOT;
            end
            // Set beats acknowledge; an acked expiry is not an overrun.
            if (expire)       pending_q <= 1'b1;
            else if (irq_ack) pending_q <= 1'b0;
            if (cfg_fire)                            overrun_q <= 1'b0;
            else if (expire && pending_q && !irq_ack) overrun_q <= 1'b1;
        end
    end

    assign expired = expired_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

    timer_counter #(.Width(Width)) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .count  (count)
    );
endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer (Width=8 and Width=4 instances).
module tb_interval_timer;
    logic       clk = 1'b0;
    logic       reset, cfg_valid, cfg_periodic, start, stop, irq_ack;
    logic [7:0] cfg_period;
    logic       cfg_ready, busy, expired, pending, overrun;
    logic [7:0] count;
    logic       cfg_ready4, busy4, expired4, pending4, overrun4;
    logic [3:0] count4;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interval_timer #(.Width(8)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_periodic(cfg_periodic), .start(start),
        .stop(stop), .irq_ack(irq_ack), .busy(busy), .count(count),
        .expired(expired), .pending(pending), .overrun(overrun)
    );

    interval_timer #(.Width(4)) dut4 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
        .cfg_period(cfg_period[3:0]), .cfg_periodic(cfg_periodic), .start(start),
        .stop(stop), .irq_ack(irq_ack), .busy(busy4), .count(count4),
        .expired(expired4), .pending(pending4), .overrun(overrun4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic per);
        cfg_valid = 1'b1; cfg_period = p; cfg_periodic = per;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cfg_ready, busy, count, expired, pending, overrun} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b busy=%b cnt=%0d exp=%b pend=%b ovr=%b, want 1 0 0 0 0 0",
                     cfg_ready, busy, count, expired, pending, overrun);
        end
    endtask

    task automatic test_oneshot();
        do_cfg(8'd5, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (busy !== 1'b1 || count !== 8'(c - 1) || expired !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_count c=%0d: got busy=%b cnt=%0d exp=%b, want 1 %0d 0", c, busy, count, expired, c - 1);
            end
            if (c < 5) tick();
        end
        tick();
        checks++;
        if (expired !== 1'b1 || busy !== 1'b0 || pending !== 1'b1 || count !== 8'd0) begin
            errors++;
            $display("FAIL oneshot_expiry: got exp=%b busy=%b pend=%b cnt=%0d, want 1 0 1 0", expired, busy, pending, count);
        end
        tick();
        checks++;
        if (expired !== 1'b0 || pending !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_pulse_width: got exp=%b pend=%b, want 0 1", expired, pending);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        checks++;
        if (pending !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ack_clears: got pend=%b ovr=%b, want 0 0", pending, overrun);
        end
    endtask

    task automatic test_periodic();
        do_cfg(8'd3, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            irq_ack = (c == 10);
            tick();
            irq_ack = 1'b0;
            checks++;
            if (expired !== (c == 4 || c == 7 || c == 10) || busy !== 1'b1) begin
                errors++;
                $display("FAIL periodic_pulse c=%0d: got exp=%b busy=%b, want %b 1", c, expired, busy, (c == 4 || c == 7 || c == 10));
            end
            if (c == 7) begin
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL periodic_overrun: got %b, want 1", overrun);
                end
            end
        end
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL ack_vs_expiry: got pend=%b, want 1", pending);
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_stop_terminal();
        do_cfg(8'd4, 1'b1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL cfg_clears_overrun: got %b, want 0", overrun);
        end
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (count !== 8'd3) begin
            errors++;
            $display("FAIL stop_setup: got cnt=%0d, want 3", count);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 8'd0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL stop_terminal: got busy=%b cnt=%0d exp=%b, want 0 0 0", busy, count, expired);
        end
        tick();
        checks++;
        if (expired !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_late_pulse: got exp=%b busy=%b, want 0 0", expired, busy);
        end
    endtask

    task automatic test_cfg_with_start();
        cfg_valid = 1'b1; cfg_period = 8'd2; cfg_periodic = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; cfg_period = 8'd9;
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL cfg_start_k1: got busy=%b rdy=%b cnt=%0d, want 1 0 0", busy, cfg_ready, count);
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b0 || count !== 8'd1 || expired !== 1'b0) begin
            errors++;
            $display("FAIL cfg_start_k2: got rdy=%b cnt=%0d exp=%b, want 0 1 0", cfg_ready, count, expired);
        end
        tick();
        checks++;
        if (expired !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_start_k3: got exp=%b busy=%b rdy=%b, want 1 0 1", expired, busy, cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_zero_period();
        do_cfg(8'd0, 1'b0);
        start = 1'b1; tick();
        checks++;
        if (busy !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL zero_period: got busy=%b cnt=%0d, want 0 0", busy, count);
        end
        tick(); start = 1'b0;
        checks++;
        if (busy !== 1'b0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL zero_period_hold: got busy=%b exp=%b, want 0 0", busy, expired);
        end
    endtask

    task automatic test_width4_max();
        do_reset();
        do_cfg(8'd15, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if (count4 !== 4'(c - 1) || expired4 !== 1'b0 || busy4 !== 1'b1) begin
                errors++;
                $display("FAIL w4_count c=%0d: got cnt=%0d exp=%b busy=%b, want %0d 0 1", c, count4, expired4, busy4, c - 1);
            end
            tick();
        end
        checks++;
        if (expired4 !== 1'b1 || count4 !== 4'd0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL w4_expiry: got exp=%b cnt=%0d busy=%b, want 1 0 0", expired4, count4, busy4);
        end
    endtask

    task automatic test_reset_midrun();
        do_cfg(8'd5, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        checks++;
        if (count !== 8'd2) begin
            errors++;
            $display("FAIL midrun_setup: got cnt=%0d, want 2", count);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if ({cfg_ready, busy, count, expired, pending, overrun} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrun_reset: got rdy=%b busy=%b cnt=%0d exp=%b pend=%b ovr=%b, want 1 0 0 0 0 0",
                     cfg_ready, busy, count, expired, pending, overrun);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (expired !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrun_quiet c=%0d: got exp=%b busy=%b, want 0 0", c, expired, busy);
            end
        end
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_periodic = 1'b0;
        start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
        #1;
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop_terminal();
        test_cfg_with_start();
        test_zero_period();
        test_width4_max();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
